score_keeper: RTL and testbench

//   Score-producing end of the game-state interface. Debounces two raw point buttons and

---
 rtl/score_keeper.sv | 86 ++++++++
 tb/tb_score_keeper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Debounces two point buttons and keeps a saturating score per player.
// Scoring is gated by the game-state block's stateGm and cleared by new_game.
module score_keeper #(
    parameter int SCR_W     = 4,
    parameter int WIN_SCORE = 5,
    parameter int DB_TICKS  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1ms,
    input  logic             p1_btn,
    input  logic             p2_btn,
    input  logic             new_game,
    input  logic [1:0]       stateGm,
    output logic [SCR_W-1:0] p1_scr,
    output logic [SCR_W-1:0] p2_scr,
    output logic             p1_pt,
    output logic             p2_pt
);

    localparam int CNT_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_TICKS - 1);
    localparam logic [SCR_W-1:0] WIN    = SCR_W'(WIN_SCORE);
    localparam logic [1:0]       ST_PLAYING = 2'b01;

    logic [1:0]       btn;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       db_lvl;
    logic [1:0]       db_lvl_q;
    logic [1:0]       req;
    logic [1:0]       pt;
    logic [CNT_W-1:0] db_cnt [2];
    logic [SCR_W-1:0] scr    [2];

    assign btn = {p2_btn, p1_btn};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_lvl   <= '0;
            db_lvl_q <= '0;
            req      <= '0;
            pt       <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
                scr[i]    <= '0;
            end
        end else begin
            sync_a   <= btn;
            sync_b   <= sync_a;
            db_lvl_q <= db_lvl;
            req      <= db_lvl & ~db_lvl_q;
            for (int i = 0; i < 2; i++) begin
                // any agreement with the current level restarts the stability window
                if (sync_b[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (clk_1ms) begin
                    if (db_cnt[i] == CNT_TC) begin
                        db_lvl[i] <= ~db_lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end

                if (new_game) begin
                    scr[i] <= '0;
                    pt[i]  <= 1'b0;
                end else if (req[i] && stateGm == ST_PLAYING && scr[i] < WIN) begin
                    scr[i] <= scr[i] + 1'b1;
                    pt[i]  <= 1'b1;
                end else begin
                    pt[i]  <= 1'b0;
                end
            end
        end
    end

    assign p1_scr = scr[0];
    assign p2_scr = scr[1];
    assign p1_pt  = pt[0];
    assign p2_pt  = pt[1];

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected point pulses (score and cycle)
// are queued when a press is driven and popped when the DUT pulses.
module tb_score_keeper;

    localparam int SCR_W     = 4;
    localparam int WIN_SCORE = 5;
    localparam int DB_TICKS  = 10;

    typedef struct {
        int score;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_1ms;
    logic             p1_btn;
    logic             p2_btn;
    logic             new_game;
    logic [1:0]       stateGm;
    logic [SCR_W-1:0] p1_scr;
    logic [SCR_W-1:0] p2_scr;
    logic             p1_pt;
    logic             p2_pt;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m1     = 0;
    int   m2     = 0;
    exp_t q1[$];
    exp_t q2[$];

    score_keeper #(
        .SCR_W    (SCR_W),
        .WIN_SCORE(WIN_SCORE),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_1ms (clk_1ms),
        .p1_btn  (p1_btn),
        .p2_btn  (p2_btn),
        .new_game(new_game),
        .stateGm (stateGm),
        .p1_scr  (p1_scr),
        .p2_scr  (p2_scr),
        .p1_pt   (p1_pt),
        .p2_pt   (p2_pt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (p1_pt === 1'b1) begin
            if (q1.size() == 0) begin
                check("p1_unexpected_pulse", 1, 0);
            end else begin
                e = q1.pop_front();
                check("p1_pulse_score", int'(p1_scr), e.score);
                check("p1_pulse_cycle", cyc, e.cyc);
            end
        end
        if (p2_pt === 1'b1) begin
            if (q2.size() == 0) begin
                check("p2_unexpected_pulse", 1, 0);
            end else begin
                e = q2.pop_front();
                check("p2_pulse_score", int'(p2_scr), e.score);
                check("p2_pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks return 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The ms pulse is sampled on the edge after the call, so a point it
    // completes pulses at (cyc at call) + 3.
    task automatic tick();
        @(negedge clk);
        clk_1ms = 1'b1;
        @(posedge clk);
        #1 clk_1ms = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_pt(input int player);
        exp_t e;
        if (player == 1) begin
            m1++;
            e.score = m1;
            e.cyc   = cyc + 3;
            q1.push_back(e);
        end else begin
            m2++;
            e.score = m2;
            e.cyc   = cyc + 3;
            q2.push_back(e);
        end
    endtask

    task automatic check_scores(input string tag);
        check({tag, "_p1_scr"}, int'(p1_scr), m1);
        check({tag, "_p2_scr"}, int'(p2_scr), m2);
    endtask

    task automatic release_btns();
        p1_btn = 1'b0;
        p2_btn = 1'b0;
        step(3);
        repeat (DB_TICKS) tick();
    endtask

    // Clean press held for 12 ticks, then release.
    task automatic press(input bit do1, input bit do2, input string tag);
        bit acc1;
        bit acc2;
        p1_btn = do1;
        p2_btn = do2;
        step(3);
        repeat (DB_TICKS - 1) tick();
        check_scores({tag, "_early"});
        acc1 = do1 && stateGm == 2'b01 && m1 < WIN_SCORE;
        acc2 = do2 && stateGm == 2'b01 && m2 < WIN_SCORE;
        if (acc1) expect_pt(1);
        if (acc2) expect_pt(2);
        tick();
        check_scores({tag, "_after"});
        repeat (2) tick();
        check_scores({tag, "_held"});
        release_btns();
    endtask

    initial begin
        reset    = 1'b0;
        clk_1ms  = 1'b0;
        p1_btn   = 1'b1;
        p2_btn   = 1'b1;
        new_game = 1'b0;
        stateGm  = 2'b00;

        step(3);
        check_scores("reset");
        check("reset_p1_pt", int'(p1_pt), 0);
        check("reset_p2_pt", int'(p2_pt), 0);

        reset = 1'b1;
        step(4);
        check_scores("post_reset");
        press(1'b1, 1'b1, "begin_state");

        stateGm = 2'b01;
        press(1'b1, 1'b0, "p1_first");
        press(1'b1, 1'b0, "p1_second");
        check("p1_is_2", int'(p1_scr), 2);

        // bounce: 4 ticks high, 1 tick low, then the window restarts
        p2_btn = 1'b1;
        step(3);
        repeat (4) tick();
        p2_btn = 1'b0;
        step(3);
        tick();
        p2_btn = 1'b1;
        step(3);
        repeat (DB_TICKS - 1) tick();
        check("bounce_p2_no_point", int'(p2_scr), 0);
        expect_pt(2);
        tick();
        check("bounce_p2_scored", int'(p2_scr), 1);
        release_btns();

        press(1'b0, 1'b1, "p2_to_2");
        press(1'b1, 1'b1, "both_a");
        press(1'b1, 1'b1, "both_b");
        check("p1_is_4", int'(p1_scr), 4);
        check("p2_is_4", int'(p2_scr), 4);
        press(1'b1, 1'b1, "both_win");
        check("p1_sat", int'(p1_scr), WIN_SCORE);
        check("p2_sat", int'(p2_scr), WIN_SCORE);
        press(1'b1, 1'b1, "both_saturated");

        stateGm = 2'b10;
        press(1'b0, 1'b1, "p2_after_win");
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        m1 = 0;
        m2 = 0;
        check_scores("new_game");
        stateGm = 2'b01;
        press(1'b0, 1'b1, "p2_new_game");
        check("p2_is_1", int'(p2_scr), 1);

        // reset with the p1 debounce counter at 7
        p1_btn = 1'b1;
        step(3);
        repeat (7) tick();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        m1 = 0;
        m2 = 0;
        check_scores("mid_db_reset");
        step(3);
        repeat (DB_TICKS - 1) tick();
        check("reset_db_no_point", int'(p1_scr), 0);
        expect_pt(1);
        tick();
        check("reset_db_scored", int'(p1_scr), 1);
        release_btns();

        step(4);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
